// File: rtl/theta_row_serializer.sv
// theta_row_serializer: takes one 25-lane state word and emits it as five
// 5-lane plane words, plane 0 first, with a valid/ready handshake on each side.
// The last beat can reload a new state word, so words stream with no bubble.
module theta_row_serializer #(
  parameter int LANE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [25*LANE_W-1:0]  in_state,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [5*LANE_W-1:0]   out_plane,
  output logic [2:0]            m_idx,
  output logic                  m_last,
  output logic                  busy
);

  localparam int PW = 5 * LANE_W;
  localparam int SW = 25 * LANE_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_buf;
  logic [2:0]      r_idx;
  logic [PW-1:0]   r_plane;
  logic            w_last_xfer;
  logic            w_capture;
  logic            w_advance;

  // Plane i sits at the top of the state word for i=0, descending.
  function automatic logic [PW-1:0] plane_of(input logic [SW-1:0] w,
                                             input logic [2:0]    i);
    plane_of = w[SW-1-PW*int'(i) -: PW];
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake decode; s_ready never looks at s_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_last_xfer = (r_state == SEND) && m_ready && (r_idx == 3'd4);
    s_ready     = (r_state == IDLE) || w_last_xfer;
    w_capture   = s_valid && s_ready;
    w_advance   = (r_state == SEND) && m_ready && (r_idx != 3'd4);
    case (r_state)
      IDLE:    if (s_valid) w_state_nxt = SEND;
      SEND:    if (w_last_xfer && !s_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Buffer, plane index and registered output plane. The buffer only loads
  // on a capture, so a stray s_valid mid-word cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_idx   <= 3'd0;
      r_plane <= '0;
    end else if (w_capture) begin
      r_buf   <= in_state;
      r_idx   <= 3'd0;
      r_plane <= plane_of(in_state, 3'd0);
    end else if (w_advance) begin
      r_idx   <= r_idx + 3'd1;
      r_plane <= plane_of(r_buf, r_idx + 3'd1);
    end
  end

  assign m_valid   = (r_state == SEND);
  assign busy      = (r_state == SEND);
  assign m_idx     = r_idx;
  assign out_plane = r_plane;
  assign m_last    = m_valid && (r_idx == 3'd4);

endmodule

// File: tb/tb_theta_row_serializer.sv
// Directed bench for theta_row_serializer plus a randomized stall run
// checked against a small behavioural model.
module tb_theta_row_serializer;

  localparam int LW = 64;
  localparam int PW = 5 * LW;
  localparam int SW = 25 * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] in_state;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] out_plane;
  logic [2:0]    m_idx;
  logic          m_last;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  theta_row_serializer #(.LANE_W(LW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .in_state(in_state), .m_valid(m_valid), .m_ready(m_ready),
    .out_plane(out_plane), .m_idx(m_idx), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pl(input logic [SW-1:0] w, input int i);
    return w[SW-1-PW*i -: PW];
  endfunction

  // Plane k of a directed word: every nibble equals base+k+1.
  function automatic logic [SW-1:0] mkword(input int base);
    logic [SW-1:0] w;
    logic [3:0]    n;
    for (int k = 0; k < 5; k++) begin
      n = 4'(base + k + 1);
      w[SW-1-PW*k -: PW] = {80{n}};
    end
    return w;
  endfunction

  function automatic logic [SW-1:0] rndword();
    logic [SW-1:0] w;
    for (int k = 0; k < SW/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  logic [SW-1:0] w1, w2, w3, w4, w5, w6;
  logic [15:0]   pat;

  initial begin
    w1 = mkword(0);  // planes 1..5
    w2 = mkword(5);
    w3 = mkword(8);
    w4 = mkword(2);
    w5 = mkword(3);
    w6 = mkword(9);

    // ---- reset values
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; in_state = '0;
    tick(); tick();
    chk("rst_m_valid", PW'(m_valid), PW'(0));
    chk("rst_s_ready", PW'(s_ready), PW'(1));
    chk("rst_m_idx",   PW'(m_idx),   PW'(0));
    chk("rst_m_last",  PW'(m_last),  PW'(0));
    chk("rst_busy",    PW'(busy),    PW'(0));
    chk("rst_plane",   out_plane,    PW'(0));
    rst = 1'b0;
    tick();

    // ---- reset mid-SEND at m_idx=2
    s_valid = 1'b1; in_state = w1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    chk("mid_idx2", PW'(m_idx), PW'(2));
    m_ready = 1'b0; rst = 1'b1;
    tick();
    chk("mrst_m_valid", PW'(m_valid), PW'(0));
    chk("mrst_s_ready", PW'(s_ready), PW'(1));
    chk("mrst_m_idx",   PW'(m_idx),   PW'(0));
    chk("mrst_busy",    PW'(busy),    PW'(0));
    rst = 1'b0;
    tick(); tick();
    chk("mrst_no_emit", PW'(m_valid), PW'(0));

    // ---- single word, m_ready held high
    s_valid = 1'b1; in_state = w1; m_ready = 1'b1;
    #1 chk("t2_s_ready_idle", PW'(s_ready), PW'(1));
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_valid%0d", k), PW'(m_valid), PW'(1));
      chk($sformatf("t2_idx%0d", k),   PW'(m_idx),   PW'(k));
      chk($sformatf("t2_plane%0d", k), out_plane,    {80{4'(k+1)}});
      chk($sformatf("t2_last%0d", k),  PW'(m_last),  PW'(k == 4));
      tick();
    end
    chk("t2_idle_valid", PW'(m_valid), PW'(0));
    chk("t2_idle_busy",  PW'(busy),    PW'(0));

    // ---- m_ready toggling: frozen output, exactly five transfers
    pat = 16'b1011_0101_1001_1001; // bit c used on cycle c
    s_valid = 1'b1; in_state = w2;
    tick();
    s_valid = 1'b0;
    begin
      int e = 0;
      int c = 0;
      while (e < 5 && c < 16) begin
        m_ready = pat[c];
        chk($sformatf("t3_valid_c%0d", c), PW'(m_valid), PW'(1));
        chk($sformatf("t3_idx_c%0d", c),   PW'(m_idx),   PW'(e));
        chk($sformatf("t3_plane_c%0d", c), out_plane,    pl(w2, e));
        if (m_ready) e++;
        c++;
        tick();
      end
      chk("t3_xfers", PW'(e), PW'(5));
    end
    chk("t3_idle", PW'(m_valid), PW'(0));

    // ---- back-to-back words, s_valid held high
    m_ready = 1'b1; s_valid = 1'b1; in_state = w3;
    #1 chk("t4_s_ready_c0", PW'(s_ready), PW'(1));
    tick();
    in_state = w4;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) s_valid = 1'b0;
      #1;
      chk($sformatf("t4_plane%0d", c),  out_plane, (c < 5) ? pl(w3, c) : pl(w4, c - 5));
      chk($sformatf("t4_sready%0d", c), PW'(s_ready), PW'(c == 4 || c == 9));
      tick();
    end
    chk("t4_idle", PW'(m_valid), PW'(0));

    // ---- s_valid pulse mid-word is ignored
    s_valid = 1'b1; in_state = w5;
    tick();
    s_valid = 1'b0;
    tick();
    s_valid = 1'b1; in_state = w6;
    #1 chk("t5_sready_mid", PW'(s_ready), PW'(0));
    tick();
    s_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      chk($sformatf("t5_plane%0d", k), out_plane, pl(w5, k));
      tick();
    end
    chk("t5_idle", PW'(m_valid), PW'(0));
    s_valid = 1'b1; in_state = w6;
    tick();
    s_valid = 1'b0;
    chk("t5_new_plane0", out_plane, pl(w6, 0));
    for (int k = 0; k < 5; k++) tick();

    // ---- random stalls vs model
    begin
      logic [SW-1:0] mbuf, cand;
      logic          mbusy = 1'b0;
      int            midx  = 0;
      int            words = 0;
      int            cyc   = 0;
      logic          exp_sr;
      m_ready = 1'b0; s_valid = 1'b0;
      cand = rndword();
      while ((words < 1000 || mbusy) && cyc < 40000) begin
        chk("rnd_valid", PW'(m_valid), PW'(mbusy));
        if (mbusy) begin
          chk("rnd_idx",   PW'(m_idx),   PW'(midx));
          chk("rnd_plane", out_plane,    pl(mbuf, midx));
          chk("rnd_last",  PW'(m_last),  PW'(midx == 4));
        end
        m_ready = ($urandom_range(0, 3) != 0);
        if (!s_valid) s_valid = (words < 1000) && ($urandom_range(0, 9) < 7);
        in_state = cand;
        #1;
        exp_sr = !mbusy || (m_ready && midx == 4);
        chk("rnd_sready", PW'(s_ready), PW'(exp_sr));
        @(posedge clk);
        #1;
        if (s_valid && exp_sr) begin
          mbuf = cand; midx = 0; mbusy = 1'b1; words++;
          s_valid = 1'b0; cand = rndword();
        end else if (mbusy && m_ready) begin
          if (midx == 4) mbusy = 1'b0;
          else midx++;
        end
        cyc++;
      end
      chk("rnd_words_done", PW'(words), PW'(1000));
      s_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
